// File: rtl/tcp_pkg.sv
// Shared constants and FSM state type for the TCP checksum insertion stage.
package tcp_pkg;
  localparam int         TCP_HDR_LEN  = 20;
  localparam int         TCP_CSUM_OFS = 16;
  localparam logic [7:0] TCP_PROTO    = 8'd6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FINAL,
    ST_DRAIN
  } csum_state_t;
endpackage

// File: rtl/tcp_csum_insert_sdp_ram.sv
// Simple dual-port byte RAM: synchronous write, registered read, one-cycle latency.
module sdp_ram #(
  parameter int DEPTH = 1480,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/utils.svh
// Shared arithmetic helpers for the checksum datapath.
`ifndef UTILS_SVH
`define UTILS_SVH
// 16-bit ones'-complement addition: the carry out wraps back into bit 0.
function automatic logic [15:0] ones_comp(input logic [15:0] a, input logic [15:0] b);
  logic [16:0] s;
  s = {1'b0, a} + {1'b0, b};
  return s[15:0] + {15'b0, s[16]};
endfunction
`endif

// File: rtl/tcp_csum_insert.sv
// Store-and-forward TCP segment buffer: sums the segment on the way in and
// replays it with the checksum written into bytes 16-17.
module tcp_csum_insert
  import tcp_pkg::*;
#(
  parameter int MAX_LEN = 1480,
  parameter int LW      = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic [15:0]   s_phdr_sum,
  output logic          m_valid,
  output logic [7:0]    m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic [LW-1:0] m_len,
  output logic          err,
  output csum_state_t   dbg_state
);
  `include "utils.svh"

  // Handshakes on both ports: a byte moves on a cycle where valid && ready;
  // the sender holds valid/data/last stable until ready is seen.
  localparam logic [LW-1:0] MAX_PTR  = LW'(MAX_LEN);
  localparam logic [LW-1:0] RUNT_PTR = LW'(TCP_HDR_LEN - 1);
  localparam logic [LW-1:0] OFS_HI   = LW'(TCP_CSUM_OFS);
  localparam logic [LW-1:0] OFS_LO   = LW'(TCP_CSUM_OFS + 1);

  csum_state_t   state_q, state_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] pend_idx_q, pend_idx_d, len_q, len_d;
  logic [15:0]   sum_q, sum_d, csum_q, csum_d;
  logic [7:0]    hi_q, hi_d, m_data_q, m_data_d;
  logic          discard_q, discard_d, rd_pend_q, rd_pend_d;
  logic          s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d, err_q, err_d;
  logic          ram_we, ram_re, s_hs, can_load;
  logic [LW-1:0] ram_raddr;
  logic [7:0]    ram_rdata, in_byte;

  sdp_ram #(.DEPTH(MAX_LEN), .AW(LW)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign s_hs     = s_valid && s_ready_q;
  assign can_load = !m_valid_q || m_ready;
  // The checksum field itself contributes zero to the sum.
  assign in_byte  = (wr_ptr_q == OFS_HI || wr_ptr_q == OFS_LO) ? 8'h00 : s_data;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pend_idx_d = pend_idx_q;
    len_d      = len_q;
    sum_d      = sum_q;
    csum_d     = csum_q;
    hi_d       = hi_q;
    discard_d  = discard_q;
    rd_pend_d  = rd_pend_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    err_d      = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_raddr  = rd_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_hs) begin
          if (discard_q) begin
            if (s_last) discard_d = 1'b0;
          end else if (s_last) begin
            err_d = 1'b1;
          end else begin
            ram_we   = 1'b1;
            hi_d     = s_data;
            sum_d    = s_phdr_sum;
            wr_ptr_d = LW'(1);
            state_d  = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (s_hs) begin
          if (wr_ptr_q == MAX_PTR) begin
            err_d     = 1'b1;
            discard_d = !s_last;
            wr_ptr_d  = '0;
            state_d   = ST_IDLE;
          end else if (s_last && wr_ptr_q < RUNT_PTR) begin
            err_d    = 1'b1;
            wr_ptr_d = '0;
            state_d  = ST_IDLE;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + LW'(1);
            if (!wr_ptr_q[0]) begin
              hi_d = in_byte;
              if (s_last) sum_d = ones_comp(sum_q, {in_byte, 8'h00});
            end else begin
              sum_d = ones_comp(sum_q, {hi_q, in_byte});
            end
            if (s_last) state_d = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        csum_d     = ~sum_q;
        len_d      = wr_ptr_q;
        ram_re     = 1'b1;
        ram_raddr  = '0;
        rd_ptr_d   = LW'(1);
        pend_idx_d = '0;
        rd_pend_d  = 1'b1;
        state_d    = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The RAM output register acts as a one-entry skid: it is only
        // refilled when its byte moves into the output register.
        if (can_load) begin
          m_valid_d = rd_pend_q;
          if (rd_pend_q) begin
            m_data_d = (pend_idx_q == OFS_HI) ? csum_q[15:8] :
                       (pend_idx_q == OFS_LO) ? csum_q[7:0]  : ram_rdata;
            m_last_d = (pend_idx_q == len_q - LW'(1));
          end
          rd_pend_d = (rd_ptr_q < len_q);
          if (rd_ptr_q < len_q) begin
            ram_re     = 1'b1;
            rd_ptr_d   = rd_ptr_q + LW'(1);
            pend_idx_d = rd_ptr_q;
          end
        end
        if (m_valid_q && m_ready && m_last_q) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          rd_pend_d = 1'b0;
          ram_re    = 1'b0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pend_idx_q <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      csum_q     <= '0;
      hi_q       <= '0;
      discard_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_idx_q <= pend_idx_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      csum_q     <= csum_d;
      hi_q       <= hi_d;
      discard_q  <= discard_d;
      rd_pend_q  <= rd_pend_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign m_len     = len_q;
  assign err       = err_q;
  assign dbg_state = state_q;
endmodule
